simd_seq_ctrl: RTL and testbench

Instruction-level sequencer for the SIMD fetch/operand path. It decodes the current 32-bit instruction and steps the operand loader through its phases: A-broadcast, B row-by-row load, execute, and result drive-out. It then pulses DONE to advance the program counter. It sits between the fetch unit, operand memory and the SIMD execute array.

---
 rtl/simd_pkg.sv | 30 +++
 rtl/simd_row_walker.sv | 59 +++++
 rtl/simd_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_simd_seq_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared types for the SIMD instruction sequencer: opcodes, FSM states and
// instruction field positions.
package simd_pkg;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 28;
    localparam int OPC_W  = OPC_HI - OPC_LO + 1;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 4'h0,
        OP_LDA  = 4'h1,
        OP_LDB  = 4'h2,
        OP_EXE  = 4'h3,
        OP_STR  = 4'h4,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_LDA,
        S_LDB,
        S_EXEC,
        S_STR,
        S_RETIRE,
        S_HALT
    } state_e;

endpackage

// File: rtl/simd_row_walker.sv
// Row walker shared by the B-load and result-store phases: counts rows 0..N-1,
// advancing on each handshake ack, and forms base+idx addresses (wrapping).
module simd_row_walker #(
    parameter int N  = 16,
    parameter int AW = 9,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          step_ack_i,
    input  logic [AW-1:0] base_i,
    output logic [IW-1:0] idx_o,
    output logic [AW-1:0] addr_o,
    output logic          last_o,
    output logic          busy_o
);

    logic [IW-1:0] idx_q, idx_d;
    logic [AW-1:0] base_q, base_d;
    logic          busy_q, busy_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q  <= '0;
            base_q <= '0;
            busy_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            base_q <= base_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        idx_d  = idx_q;
        base_d = base_q;
        busy_d = busy_q;
        if (start_i) begin
            idx_d  = '0;
            base_d = base_i;
            busy_d = 1'b1;
        end else if (busy_q && step_ack_i) begin
            // Counter returns to 0 after the last row so the next walk starts clean.
            if (last_o) begin
                idx_d  = '0;
                busy_d = 1'b0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    assign idx_o  = idx_q;
    assign addr_o = base_q + AW'(idx_q);
    assign last_o = busy_q && (idx_q == IW'(N - 1));
    assign busy_o = busy_q;

endmodule

// File: rtl/simd_seq_ctrl.sv
// Instruction sequencer: decodes INSTR, then drives A-broadcast, B row load,
// execute and result drive-out phases before pulsing DONE to retire.
module simd_seq_ctrl
    import simd_pkg::*;
#(
    parameter int N    = 16,
    parameter int REGN = 512,
    parameter int AW   = $clog2(REGN)
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 START,
    input  logic [31:0]          INSTR,
    output logic                 RD_REQ,
    output logic [AW-1:0]        RD_ADDR,
    input  logic                 RD_VALID,
    output logic                 MAT_WE,
    output logic                 MATAB_MUX,
    output logic [$clog2(N)-1:0] SEQ_B,
    output logic                 EXEC_START,
    input  logic                 EXEC_DONE,
    output logic                 DOUT_MUX,
    output logic                 WR_EN,
    output logic [AW-1:0]        WR_ADDR,
    output logic [$clog2(N)-1:0] RES_ROW,
    input  logic                 WR_ACK,
    output logic                 DONE,
    output logic                 BUSY,
    output logic                 HALTED,
    output logic                 ERR
);

    localparam int IW = $clog2(N);

    state_e        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic          err_q, err_d;
    logic          exec_first_q, exec_first_d;

    logic          walk_start, walk_ack, walk_last, walk_busy;
    logic [IW-1:0] walk_idx;
    logic [AW-1:0] walk_addr;

    // Instruction bits between the opcode and the base address carry no meaning.
    logic unused_instr;
    assign unused_instr = ^INSTR[OPC_LO-1:AW];

    simd_row_walker #(
        .N  (N),
        .AW (AW)
    ) u_walker (
        .clk_i      (CLK),
        .rst_i      (RSTN),
        .start_i    (walk_start),
        .step_ack_i (walk_ack),
        .base_i     (INSTR[AW-1:0]),
        .idx_o      (walk_idx),
        .addr_o     (walk_addr),
        .last_o     (walk_last),
        .busy_o     (walk_busy)
    );

    always_ff @(posedge CLK or posedge RSTN) begin
        if (RSTN) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            err_q        <= 1'b0;
            exec_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            err_q        <= err_d;
            exec_first_q <= exec_first_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        err_d        = err_q;
        exec_first_d = 1'b0;
        walk_start   = 1'b0;
        walk_ack     = 1'b0;
        RD_REQ       = 1'b0;
        RD_ADDR      = '0;
        MAT_WE       = 1'b0;
        MATAB_MUX    = 1'b0;
        SEQ_B        = '0;
        EXEC_START   = 1'b0;
        DOUT_MUX     = 1'b0;
        WR_EN        = 1'b0;
        WR_ADDR      = '0;
        RES_ROW      = '0;
        DONE         = 1'b0;
        HALTED       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                base_d = INSTR[AW-1:0];
                case (INSTR[OPC_HI:OPC_LO])
                    OP_NOP:  state_d = S_RETIRE;
                    OP_LDA:  state_d = S_LDA;
                    OP_LDB: begin
                        state_d    = S_LDB;
                        walk_start = 1'b1;
                    end
                    OP_EXE: begin
                        state_d      = S_EXEC;
                        exec_first_d = 1'b1;
                    end
                    OP_STR: begin
                        state_d    = S_STR;
                        walk_start = 1'b1;
                    end
                    OP_HALT: state_d = S_HALT;
                    default: begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end
                endcase
            end
            S_LDA: begin
                RD_REQ  = 1'b1;
                RD_ADDR = base_q;
                if (RD_VALID) begin
                    MAT_WE    = 1'b1;
                    MATAB_MUX = 1'b1;
                    state_d   = S_RETIRE;
                end
            end
            S_LDB: begin
                RD_REQ   = walk_busy;
                RD_ADDR  = walk_addr;
                SEQ_B    = walk_idx;
                walk_ack = RD_VALID;
                MAT_WE   = RD_VALID;
                if (RD_VALID && walk_last) state_d = S_RETIRE;
            end
            S_EXEC: begin
                // Completion may arrive in the same cycle as the start pulse.
                EXEC_START = exec_first_q;
                if (EXEC_DONE) state_d = S_RETIRE;
            end
            S_STR: begin
                DOUT_MUX = 1'b1;
                WR_EN    = walk_busy;
                WR_ADDR  = walk_addr;
                RES_ROW  = walk_idx;
                walk_ack = WR_ACK;
                if (WR_ACK && walk_last) state_d = S_RETIRE;
            end
            S_RETIRE: begin
                DONE    = 1'b1;
                state_d = START ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                HALTED = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign BUSY = (state_q != S_IDLE) && (state_q != S_HALT);
    assign ERR  = err_q;

endmodule

// File: tb/tb_simd_seq_ctrl.sv
// Bench for simd_seq_ctrl: directed and randomized instructions with
// handshake latencies chosen up front; expected timing and traffic come from them.
module tb_simd_seq_ctrl;

    localparam int N  = 16;
    localparam int AW = 9;
    localparam int IW = 4;

    logic          CLK = 1'b0;
    logic          RSTN, START, RD_VALID, EXEC_DONE, WR_ACK;
    logic [31:0]   INSTR;
    logic          RD_REQ, MAT_WE, MATAB_MUX, EXEC_START, DOUT_MUX, WR_EN;
    logic          DONE, BUSY, HALTED, ERR;
    logic [AW-1:0] RD_ADDR, WR_ADDR;
    logic [IW-1:0] SEQ_B, RES_ROW;

    int errors = 0;
    int checks = 0;
    int err_exp = 0;
    int waits[$];

    simd_seq_ctrl #(.N(N), .REGN(512)) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .START      (START),
        .INSTR      (INSTR),
        .RD_REQ     (RD_REQ),
        .RD_ADDR    (RD_ADDR),
        .RD_VALID   (RD_VALID),
        .MAT_WE     (MAT_WE),
        .MATAB_MUX  (MATAB_MUX),
        .SEQ_B      (SEQ_B),
        .EXEC_START (EXEC_START),
        .EXEC_DONE  (EXEC_DONE),
        .DOUT_MUX   (DOUT_MUX),
        .WR_EN      (WR_EN),
        .WR_ADDR    (WR_ADDR),
        .RES_ROW    (RES_ROW),
        .WR_ACK     (WR_ACK),
        .DONE       (DONE),
        .BUSY       (BUSY),
        .HALTED     (HALTED),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill_waits(input int n, input int lo, input int hi);
        waits.delete();
        repeat (n) waits.push_back(int'($urandom_range(hi, lo)));
    endtask

    function automatic int all_outs_ones();
        return $countones({RD_REQ, RD_ADDR, MAT_WE, MATAB_MUX, SEQ_B, EXEC_START,
                           DOUT_MUX, WR_EN, WR_ADDR, RES_ROW, DONE, BUSY, HALTED, ERR});
    endfunction

    // Runs one instruction from IDLE; waits[] gives the handshake latencies.
    task automatic run_instr(input logic [31:0] ins, input string tag);
        int op, base, p, exp_done, last_c, hi, hcnt, ecnt;
        int ndone, done_c, nstart, viol, busy_end, wv;
        bit halt, ex_on, prw, pww;
        logic [AW-1:0] pra, pwa;
        logic [IW-1:0] prr, pwr;
        int cap_a[$], cap_r[$], cap_m[$], wr_a[$], wr_r[$];

        op   = int'(ins[31:28]);
        base = int'(ins[AW-1:0]);
        halt = (op > 4);
        p    = 0;
        if (op == 1 || op == 3) p = waits[0] + 1;
        if (op == 2 || op == 4) for (int i = 0; i < N; i++) p += waits[i] + 1;
        if (halt && op != 15) err_exp = 1;
        exp_done = 3 + p;
        last_c   = halt ? 6 : exp_done + 1;

        hi = 0; hcnt = 0; ecnt = 0; ex_on = 0; ndone = 0; done_c = -1;
        nstart = 0; viol = 0; busy_end = -1; prw = 0; pww = 0;
        pra = '0; pwa = '0; prr = '0; pwr = '0;
        INSTR = ins;

        for (int c = 0; c <= last_c; c++) begin
            @(negedge CLK);
            START = (c == 0) || halt;
            RD_VALID = 0; WR_ACK = 0; EXEC_DONE = 0;
            if (RD_REQ || WR_EN) begin
                wv = (hi < waits.size()) ? waits[hi] : 0;
                if (hcnt >= wv) begin
                    if (RD_REQ) RD_VALID = 1; else WR_ACK = 1;
                    hi++;
                    hcnt = 0;
                end else hcnt++;
            end
            if (EXEC_START) begin ex_on = 1; ecnt = 0; end
            if (ex_on) begin
                if (ecnt >= waits[0]) begin EXEC_DONE = 1; ex_on = 0; end
                else ecnt++;
            end
            #1;
            if (MAT_WE) begin
                cap_a.push_back(int'(RD_ADDR));
                cap_r.push_back(int'(SEQ_B));
                cap_m.push_back(int'(MATAB_MUX));
                if (!RD_VALID || !RD_REQ) viol++;
            end
            if (WR_EN && WR_ACK) begin
                wr_a.push_back(int'(WR_ADDR));
                wr_r.push_back(int'(RES_ROW));
            end
            if (DOUT_MUX !== WR_EN) viol++;
            if (prw && RD_REQ && (RD_ADDR !== pra || SEQ_B !== prr)) viol++;
            if (pww && WR_EN && (WR_ADDR !== pwa || RES_ROW !== pwr)) viol++;
            prw = RD_REQ && !RD_VALID; pra = RD_ADDR; prr = SEQ_B;
            pww = WR_EN && !WR_ACK;    pwa = WR_ADDR; pwr = RES_ROW;
            if (EXEC_START) nstart++;
            if (DONE) begin ndone++; done_c = c; end
            if (!halt && c >= 1 && c <= exp_done && BUSY !== 1'b1) viol++;
            if (halt && c >= 3 && BUSY !== 1'b0) viol++;
            if (c == last_c) busy_end = int'(BUSY);
        end

        chk({tag, ".done_cnt"}, ndone, halt ? 0 : 1);
        if (!halt) chk({tag, ".done_cyc"}, done_c, exp_done);
        chk({tag, ".cap_cnt"}, cap_a.size(), (op == 1) ? 1 : (op == 2) ? N : 0);
        if (op == 1 && cap_a.size() == 1) begin
            chk({tag, ".lda_addr"}, cap_a[0], base);
            chk({tag, ".lda_mux"}, cap_m[0], 1);
        end
        if (op == 2) for (int k = 0; k < cap_a.size() && k < N; k++) begin
            chk({tag, ".ldb_row"}, cap_r[k], k);
            chk({tag, ".ldb_addr"}, cap_a[k], (base + k) % 512);
            chk({tag, ".ldb_mux"}, cap_m[k], 0);
        end
        chk({tag, ".wr_cnt"}, wr_a.size(), (op == 4) ? N : 0);
        if (op == 4) for (int j = 0; j < wr_a.size() && j < N; j++) begin
            chk({tag, ".str_row"}, wr_r[j], j);
            chk({tag, ".str_addr"}, wr_a[j], (base + j) % 512);
        end
        chk({tag, ".exec_starts"}, nstart, (op == 3) ? 1 : 0);
        chk({tag, ".invariants"}, viol, 0);
        chk({tag, ".busy_end"}, busy_end, 0);
        chk({tag, ".halted"}, int'(HALTED), halt ? 1 : 0);
        chk({tag, ".err"}, int'(ERR), err_exp);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RSTN = 1;
        #1;
        chk("reset_outs", all_outs_ones(), 0);
        @(negedge CLK);
        RSTN = 0;
        err_exp = 0;
    endtask

    initial begin
        int found;
        int ops[5] = '{0, 1, 2, 3, 4};
        int rop;
        RSTN = 1; START = 0; INSTR = '0; RD_VALID = 0; EXEC_DONE = 0; WR_ACK = 0;
        repeat (2) @(negedge CLK);
        #1;
        chk("reset_outs0", all_outs_ones(), 0);
        RSTN = 0;

        fill_waits(1, 1, 1);      run_instr(32'h1000_0005, "lda");
        fill_waits(N, 0, 0);      run_instr(32'h2000_01FE, "ldb_wrap");
        fill_waits(1, 7, 7);      run_instr(32'h3000_0000, "exe_d7");
        fill_waits(1, 0, 0);      run_instr(32'h3000_0000, "exe_d0");
        fill_waits(N, 1, 1);      run_instr(32'h4000_01F8, "str_odd");
        fill_waits(1, 0, 0);      run_instr(32'h0000_0000, "nop");

        fill_waits(1, 0, 0);      run_instr(32'h7000_0000, "illegal");
        do_reset();
        chk("err_cleared", int'(ERR), 0);
        fill_waits(1, 0, 0);      run_instr(32'hF000_0000, "halt");
        do_reset();

        // Abort an LDB walk at row 8, then confirm a fresh walk starts at row 0.
        INSTR = 32'h2000_0010;
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            @(negedge CLK);
            START = (c == 0);
            RD_VALID = RD_REQ;
            if (RD_REQ && SEQ_B == 4'd8) found = 1;
        end
        chk("abort_reach", found, 1);
        #2 RSTN = 1;
        #1 chk("abort_outs", all_outs_ones(), 0);
        RD_VALID = 0;
        @(negedge CLK);
        RSTN = 0;
        err_exp = 0;
        fill_waits(N, 0, 0);      run_instr(32'h2000_0010, "ldb_restart");

        for (int it = 0; it < 8; it++) begin
            rop = ops[$urandom_range(4, 0)];
            if (rop == 3) fill_waits(1, 0, 9); else fill_waits(N, 0, 3);
            run_instr({4'(rop), 19'($urandom), 9'($urandom_range(511, 0))}, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
